// File: rtl/id_ex_hazard_reg_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_hazard_reg_pkg
//   Shared definitions for the ID/EX stage: bit positions inside the 9-bit
//   decoder control word, the link register used by JAL, and small helpers
//   that classify which source registers an ID instruction actually reads.
// ----------------------------------------------------------------------------
package id_ex_hazard_reg_pkg;

    // Control word bit positions (decoder output layout)
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMTOREG = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_REGDST   = 2;
    localparam int CTRL_JUMP     = 1;
    localparam int CTRL_JAL      = 0;

    localparam int CTRL_BITS     = 9;

    // JAL writes the return address here
    localparam logic [4:0] RA_REG = 5'd31;

    // Jumps take no register operand; everything else reads rs.
    function automatic logic uses_rs(input logic jump);
        return ~jump;
    endfunction

    // rt is a source for R-type and beq (ALUSrc=0) and for sw (store data),
    // even though sw selects the immediate for the ALU.
    function automatic logic uses_rt(input logic alusrc, input logic memwrite);
        return ~alusrc | memwrite;
    endfunction

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// ----------------------------------------------------------------------------
// id_ex_hazard_reg_if
//   Bundles the ID-stage inputs, EX-stage registered outputs and the
//   front-end hold/stall indications of the ID/EX register.
//   slave  : the pipeline register (consumes id_*, flush; drives ex_*, holds)
//   master : the surrounding core / testbench
// ----------------------------------------------------------------------------
interface id_ex_hazard_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
);
    // ID side
    logic              flush_i;
    logic [CTRL_W-1:0] id_ctrl_i;
    logic [DATA_W-1:0] id_pc4_i;
    logic [DATA_W-1:0] id_rd1_i;
    logic [DATA_W-1:0] id_rd2_i;
    logic [DATA_W-1:0] id_imm_i;
    logic [REG_W-1:0]  id_rs_i;
    logic [REG_W-1:0]  id_rt_i;
    logic [REG_W-1:0]  id_rd_i;
    logic [5:0]        id_funct_i;

    // EX side
    logic [CTRL_W-1:0] ex_ctrl_o;
    logic              ex_valid_o;
    logic [DATA_W-1:0] ex_pc4_o;
    logic [DATA_W-1:0] ex_rd1_o;
    logic [DATA_W-1:0] ex_rd2_o;
    logic [DATA_W-1:0] ex_imm_o;
    logic [REG_W-1:0]  ex_rs_o;
    logic [REG_W-1:0]  ex_rt_o;
    logic [REG_W-1:0]  ex_wreg_o;
    logic [5:0]        ex_funct_o;

    // Front-end control
    logic              pc_write_o;
    logic              ifid_write_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport slave (
        input  flush_i, id_ctrl_i, id_pc4_i, id_rd1_i, id_rd2_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i, id_funct_i,
        output ex_ctrl_o, ex_valid_o, ex_pc4_o, ex_rd1_o, ex_rd2_o, ex_imm_o,
               ex_rs_o, ex_rt_o, ex_wreg_o, ex_funct_o,
               pc_write_o, ifid_write_o, stall_o, stall_cnt_o
    );

    modport master (
        output flush_i, id_ctrl_i, id_pc4_i, id_rd1_i, id_rd2_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i, id_funct_i,
        input  ex_ctrl_o, ex_valid_o, ex_pc4_o, ex_rd1_o, ex_rd2_o, ex_imm_o,
               ex_rs_o, ex_rt_o, ex_wreg_o, ex_funct_o,
               pc_write_o, ifid_write_o, stall_o, stall_cnt_o
    );

endinterface

// File: rtl/id_ex_hazard_reg_hazard_detector.sv
// ----------------------------------------------------------------------------
// hazard_detector
//   Combinational load-use detector. Flags a stall when the instruction in EX
//   is a valid load whose destination (rt, non-zero) is read by the
//   instruction in ID. A flush suppresses the stall: the ID instruction is
//   being killed anyway, so it must not freeze the front end.
//   Inputs : id_rs/id_rt, ID Jump/ALUSrc/MemWrite, ex_rt, ex_memread,
//            ex_valid, flush
//   Output : stall
// ----------------------------------------------------------------------------
module hazard_detector
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_jump,
    input  logic             id_alusrc,
    input  logic             id_memwrite,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_memread,
    input  logic             ex_valid,
    input  logic             flush,
    output logic             stall
);

    logic rs_hit;
    logic rt_hit;
    logic ex_is_load;

    always_comb begin
        rs_hit     = uses_rs(id_jump) && (id_rs == ex_rt);
        rt_hit     = uses_rt(id_alusrc, id_memwrite) && (id_rt == ex_rt);
        // $zero is never a real dependency
        ex_is_load = ex_valid && ex_memread && (ex_rt != '0);
        stall      = ex_is_load && !flush && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ----------------------------------------------------------------------------
// id_ex_hazard_reg
//   ID/EX pipeline register with load-use hazard handling.
//   - Data fields (pc4, rd1, rd2, imm, rs, rt, funct, wreg) load every edge.
//   - Control/valid load the decoder word, or a bubble on flush or stall.
//   - Write-back register is resolved here: JAL ? $31 : RegDst ? rd : rt.
//   - pc_write_o / ifid_write_o drop for the single load-use stall cycle.
//   - stall_cnt_o counts stall cycles, saturating at all-ones.
//   Ports: clk, rst_n (async active-low), bus (id_ex_hazard_reg_if.slave).
// ----------------------------------------------------------------------------
module id_ex_hazard_reg
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    id_ex_hazard_reg_if.slave  bus
);

    // Registered state
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc4_q,   pc4_d;
    logic [DATA_W-1:0] rd1_q,   rd1_d;
    logic [DATA_W-1:0] rd2_q,   rd2_d;
    logic [DATA_W-1:0] imm_q,   imm_d;
    logic [REG_W-1:0]  rs_q,    rs_d;
    logic [REG_W-1:0]  rt_q,    rt_d;
    logic [REG_W-1:0]  wreg_q,  wreg_d;
    logic [5:0]        funct_q, funct_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic stall;

    hazard_detector #(
        .REG_W (REG_W)
    ) u_hazard (
        .id_rs       (bus.id_rs_i),
        .id_rt       (bus.id_rt_i),
        .id_jump     (bus.id_ctrl_i[CTRL_JUMP]),
        .id_alusrc   (bus.id_ctrl_i[CTRL_ALUSRC]),
        .id_memwrite (bus.id_ctrl_i[CTRL_MEMWRITE]),
        .ex_rt       (rt_q),
        .ex_memread  (ctrl_q[CTRL_MEMREAD]),
        .ex_valid    (valid_q),
        .flush       (bus.flush_i),
        .stall       (stall)
    );

    always_comb begin
        // Data path follows ID unconditionally; a bubble is marked only via
        // ctrl/valid, so stale operands in a bubble are harmless.
        pc4_d   = bus.id_pc4_i;
        rd1_d   = bus.id_rd1_i;
        rd2_d   = bus.id_rd2_i;
        imm_d   = bus.id_imm_i;
        rs_d    = bus.id_rs_i;
        rt_d    = bus.id_rt_i;
        funct_d = bus.id_funct_i;

        if (bus.id_ctrl_i[CTRL_JAL])
            wreg_d = REG_W'(RA_REG);
        else if (bus.id_ctrl_i[CTRL_REGDST])
            wreg_d = bus.id_rd_i;
        else
            wreg_d = bus.id_rt_i;

        // Flush and stall both inject a bubble; stall is already masked by
        // flush inside the detector.
        ctrl_d  = bus.id_ctrl_i;
        valid_d = 1'b1;
        if (bus.flush_i || stall) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            wreg_q  <= '0;
            funct_q <= '0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            pc4_q   <= pc4_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            wreg_q  <= wreg_d;
            funct_q <= funct_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ex_ctrl_o    = ctrl_q;
    assign bus.ex_valid_o   = valid_q;
    assign bus.ex_pc4_o     = pc4_q;
    assign bus.ex_rd1_o     = rd1_q;
    assign bus.ex_rd2_o     = rd2_q;
    assign bus.ex_imm_o     = imm_q;
    assign bus.ex_rs_o      = rs_q;
    assign bus.ex_rt_o      = rt_q;
    assign bus.ex_wreg_o    = wreg_q;
    assign bus.ex_funct_o   = funct_q;
    assign bus.stall_o      = stall;
    assign bus.pc_write_o   = ~stall;
    assign bus.ifid_write_o = ~stall;
    assign bus.stall_cnt_o  = cnt_q;

endmodule
